// File: rtl/match_count_accumulator.sv
// Per-state, per-lane match counter behind CSR_traversal, with a zero-skipping valid/ready readout.
// Build option MATCH_SAT_EN: counters saturate at all-ones instead of wrapping.
module match_count_accumulator #(
    parameter int SIZE_RANGE = 9514,
    parameter int IDX_W      = 20,
    parameter int CNT_W      = 10
) (
    input  logic             tb_clk,
    input  logic             reset,
    input  logic             accepting_match_flag,
    input  logic             accepting_match_flag_2,
    input  logic [IDX_W-1:0] i,
    input  logic             dump_req,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic             dump_lane,
    output logic [IDX_W-1:0] dump_idx,
    output logic [CNT_W-1:0] dump_count,
    output logic             dump_done,
    output logic             busy,
    output logic [15:0]      drop_cnt
);
    localparam int ADDR_W = $clog2(SIZE_RANGE);

    typedef enum logic [1:0] {CLEAR, RUN, DRAIN, DUMP} state_t;

    state_t state, state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [1:0]        drain_cnt;
    logic              dump_pend;

    logic              in_range;
    logic [1:0]        acc;
    logic [1:0]        drop_n;
    logic [16:0]       drop_sum;

    logic [1:0]        s0_v, s1_v, s2_v, w_v;
    logic [ADDR_W-1:0] s0_idx, s1_idx, s2_idx, w_idx;
    logic [CNT_W-1:0]  s2_cnt [2];
    logic [CNT_W-1:0]  w_cnt [2];
    logic [CNT_W-1:0]  base_cnt [2];
    logic [CNT_W-1:0]  nxt_cnt [2];

    logic [CNT_W-1:0]  ram_lo [SIZE_RANGE];
    logic [CNT_W-1:0]  ram_hi [SIZE_RANGE];
    logic [CNT_W-1:0]  rd_q [2];
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;

    logic [ADDR_W:0]   scan_addr;
    logic              ent_v;
    logic [ADDR_W-1:0] ent_idx;
    logic [1:0]        taken;
    logic              pend0, pend1, out_free, take, take_lane;
    logic [1:0]        remaining;
    logic              ent_done, scan_end, issue, dump_fin;

    assign in_range = (i < IDX_W'(SIZE_RANGE));
    assign acc[0]   = accepting_match_flag   && (state == RUN) && in_range;
    assign acc[1]   = accepting_match_flag_2 && (state == RUN) && in_range;
    assign drop_n   = {1'b0, accepting_match_flag && !acc[0]} + {1'b0, accepting_match_flag_2 && !acc[1]};
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_n);

    always_ff @(posedge tb_clk) begin
        if (!reset) state <= CLEAR;
        else        state <= state_nxt;
    end

    // A dump request seen at any point during CLEAR is honoured when CLEAR finishes.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: if (clr_addr == ADDR_W'(SIZE_RANGE - 1))
                       state_nxt = (dump_pend || dump_req) ? DRAIN : RUN;
            RUN:   if (dump_req) state_nxt = DRAIN;
            DRAIN: if (drain_cnt == 2'd2) state_nxt = DUMP;
            DUMP:  if (dump_fin) state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy = (state != RUN);
    end

    always_ff @(posedge tb_clk) begin
        if (!reset) begin
            clr_addr  <= '0;
            drain_cnt <= 2'd0;
            dump_pend <= 1'b0;
            drop_cnt  <= 16'd0;
        end else begin
            if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (state == CLEAR && dump_req) dump_pend <= 1'b1;
            else if (state != CLEAR)        dump_pend <= 1'b0;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge tb_clk) begin
        if (!reset) begin
            s0_v <= 2'b00;
            s1_v <= 2'b00;
            s2_v <= 2'b00;
            w_v  <= 2'b00;
        end else begin
            s0_v <= acc;
            s1_v <= s0_v;
            s2_v <= s1_v;
            w_v  <= s2_v;
        end
    end

    always_ff @(posedge tb_clk) begin
        s0_idx <= i[ADDR_W-1:0];
        s1_idx <= s0_idx;
        s2_idx <= s1_idx;
        w_idx  <= s2_idx;
        for (int l = 0; l < 2; l++) begin
            s2_cnt[l] <= nxt_cnt[l];
            w_cnt[l]  <= s2_cnt[l];
        end
    end

    // S2 holds the write landing next edge; W holds the write that raced the S1 read.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            base_cnt[l] = rd_q[l];
            if (s2_v[l] && s2_idx == s1_idx)     base_cnt[l] = s2_cnt[l];
            else if (w_v[l] && w_idx == s1_idx)  base_cnt[l] = w_cnt[l];
`ifdef MATCH_SAT_EN
            nxt_cnt[l] = (base_cnt[l] == {CNT_W{1'b1}}) ? base_cnt[l] : base_cnt[l] + CNT_W'(1);
`else
            nxt_cnt[l] = base_cnt[l] + CNT_W'(1);
`endif
        end
    end

    assign rd_addr = (state == DUMP) ? scan_addr[ADDR_W-1:0] : s0_idx;
    assign rd_en   = (state != DUMP) || issue;

    always_ff @(posedge tb_clk) begin
        if (state == CLEAR)  ram_lo[clr_addr] <= '0;
        else if (s2_v[0])    ram_lo[s2_idx]   <= s2_cnt[0];
        if (rd_en)           rd_q[0]          <= ram_lo[rd_addr];
    end

    always_ff @(posedge tb_clk) begin
        if (state == CLEAR)  ram_hi[clr_addr] <= '0;
        else if (s2_v[1])    ram_hi[s2_idx]   <= s2_cnt[1];
        if (rd_en)           rd_q[1]          <= ram_hi[rd_addr];
    end

    // The read registers double as the scan entry; a new address is read only once both lanes are emitted.
    assign pend0     = ent_v && (rd_q[0] != '0) && !taken[0];
    assign pend1     = ent_v && (rd_q[1] != '0) && !taken[1];
    assign out_free  = !dump_valid || dump_ready;
    assign take      = out_free && (pend0 || pend1);
    assign take_lane = !pend0;
    assign remaining = {pend1 && !(take && take_lane), pend0 && !(take && !take_lane)};
    assign ent_done  = (remaining == 2'b00);
    assign scan_end  = (scan_addr == (ADDR_W + 1)'(SIZE_RANGE));
    assign issue     = (state == DUMP) && ent_done && !scan_end;
    assign dump_fin  = (state == DUMP) && scan_end && !ent_v && out_free;

    always_ff @(posedge tb_clk) begin
        if (!reset) begin
            scan_addr  <= '0;
            ent_v      <= 1'b0;
            ent_idx    <= '0;
            taken      <= 2'b00;
            dump_valid <= 1'b0;
            dump_lane  <= 1'b0;
            dump_idx   <= '0;
            dump_count <= '0;
            dump_done  <= 1'b0;
        end else if (state != DUMP) begin
            scan_addr  <= '0;
            ent_v      <= 1'b0;
            taken      <= 2'b00;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= dump_fin;
            if (issue) begin
                scan_addr <= scan_addr + (ADDR_W + 1)'(1);
                ent_v     <= 1'b1;
                ent_idx   <= scan_addr[ADDR_W-1:0];
                taken     <= 2'b00;
            end else if (ent_done) begin
                ent_v <= 1'b0;
            end else if (take) begin
                taken[take_lane] <= 1'b1;
            end
            if (take) begin
                dump_valid <= 1'b1;
                dump_lane  <= take_lane;
                dump_idx   <= IDX_W'(ent_idx);
                dump_count <= take_lane ? rd_q[1] : rd_q[0];
            end else if (dump_ready) begin
                dump_valid <= 1'b0;
            end
        end
    end
endmodule
